// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock in circular, linear or
// hyperbolic coordinates, rotation or vectoring mode. Results are uncompensated.
module cordic_iter_engine #(
  parameter int BIT_WIDTH = 16,
  parameter int ITER      = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode_bit,
  input  logic [1:0]           coordinate_system,
  input  logic [BIT_WIDTH-1:0] x_in,
  input  logic [BIT_WIDTH-1:0] y_in,
  input  logic [BIT_WIDTH-1:0] z_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [BIT_WIDTH-1:0] x_out,
  output logic [BIT_WIDTH-1:0] y_out,
  output logic [BIT_WIDTH-1:0] z_out,
  output logic [5:0]           iter_idx
);

  localparam int FRAC = BIT_WIDTH - 3;
  localparam logic [1:0] CS_LIN  = 2'b00;
  localparam logic [1:0] CS_CIRC = 2'b01;
  localparam logic [1:0] CS_RSV  = 2'b10;
  localparam logic [1:0] CS_HYP  = 2'b11;
  localparam logic [63:0] PI4_Q60 = 64'd905502432259640354;

  // Angle constants are built from power series in Q60 and rounded to FRAC bits.
  function automatic logic [BIT_WIDTH-1:0] angle_q(input logic [1:0] cs, input int i);
    logic [63:0] acc;
    logic [63:0] term;
    acc = '0;
    if (cs == CS_LIN) begin
      if (i <= 60) acc = 64'd1 << (60 - i);
    end else if (cs == CS_CIRC && i == 0) begin
      acc = PI4_Q60;
    end else if (i > 0) begin
      for (int k = 1; k <= 61; k += 2) begin
        if (i * k <= 60) begin
          term = (64'd1 << (60 - i * k)) / 64'(k);
          if (cs == CS_CIRC && ((k / 2) % 2) == 1) acc = acc - term;
          else acc = acc + term;
        end
      end
    end
    acc = (acc + (64'd1 << (59 - FRAC))) >> (60 - FRAC);
    return acc[BIT_WIDTH-1:0];
  endfunction

  logic [BIT_WIDTH-1:0] tab_circ [64];
  logic [BIT_WIDTH-1:0] tab_lin  [64];
  logic [BIT_WIDTH-1:0] tab_hyp  [64];

  for (genvar g = 0; g < 64; g++) begin : g_tab
    localparam logic [BIT_WIDTH-1:0] E_CIRC = angle_q(CS_CIRC, g);
    localparam logic [BIT_WIDTH-1:0] E_LIN  = angle_q(CS_LIN, g);
    localparam logic [BIT_WIDTH-1:0] E_HYP  = angle_q(CS_HYP, g);
    assign tab_circ[g] = E_CIRC;
    assign tab_lin[g]  = E_LIN;
    assign tab_hyp[g]  = E_HYP;
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [BIT_WIDTH-1:0] x_r, y_r, z_r;
  logic [BIT_WIDTH-1:0] x_sh, y_sh, x_nxt, y_nxt, z_nxt, e_val;
  logic                 mode_r, rep_r, rep_nxt, d_pos, accept, last_step;
  logic [1:0]           cs_r;
  logic [5:0]           step_r, idx_r, idx_nxt;

  // Handshake: start is a request taken on any edge where the FSM is in IDLE or
  // DONE (ready = !busy); done is a one-cycle valid pulse with no backpressure.
  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign last_step = (cs_r == CS_RSV) || (step_r == 6'(ITER - 1));
  assign iter_idx  = idx_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_comb begin
    x_sh  = $signed(x_r) >>> idx_r;
    y_sh  = $signed(y_r) >>> idx_r;
    d_pos = mode_r ? y_r[BIT_WIDTH-1] : ~z_r[BIT_WIDTH-1];
    case (cs_r)
      CS_CIRC: e_val = tab_circ[idx_r];
      CS_HYP:  e_val = tab_hyp[idx_r];
      default: e_val = tab_lin[idx_r];
    endcase
    x_nxt = x_r;
    if (d_pos) begin
      y_nxt = y_r + x_sh;
      z_nxt = z_r - e_val;
      if (cs_r == CS_CIRC) x_nxt = x_r - y_sh;
      else if (cs_r == CS_HYP) x_nxt = x_r + y_sh;
    end else begin
      y_nxt = y_r - x_sh;
      z_nxt = z_r + e_val;
      if (cs_r == CS_CIRC) x_nxt = x_r + y_sh;
      else if (cs_r == CS_HYP) x_nxt = x_r - y_sh;
    end
    // Hyperbolic convergence needs indices 4, 13 and 40 executed twice.
    idx_nxt = idx_r + 6'd1;
    rep_nxt = 1'b0;
    if (cs_r == CS_HYP && !rep_r && (idx_r == 6'd4 || idx_r == 6'd13 || idx_r == 6'd40)) begin
      idx_nxt = idx_r;
      rep_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      mode_r <= 1'b0;
      cs_r   <= 2'b00;
      step_r <= '0;
      idx_r  <= '0;
      rep_r  <= 1'b0;
      err    <= 1'b0;
      x_out  <= '0;
      y_out  <= '0;
      z_out  <= '0;
    end else if (accept) begin
      x_r    <= x_in;
      y_r    <= y_in;
      z_r    <= z_in;
      mode_r <= mode_bit;
      cs_r   <= coordinate_system;
      step_r <= '0;
      idx_r  <= (coordinate_system == CS_HYP) ? 6'd1 : 6'd0;
      rep_r  <= 1'b0;
      err    <= 1'b0;
    end else if (state == S_RUN) begin
      if (cs_r == CS_RSV) begin
        x_out <= x_r;
        y_out <= y_r;
        z_out <= z_r;
        err   <= 1'b1;
      end else begin
        x_r    <= x_nxt;
        y_r    <= y_nxt;
        z_r    <= z_nxt;
        step_r <= step_r + 6'd1;
        idx_r  <= idx_nxt;
        rep_r  <= rep_nxt;
        if (last_step) begin
          x_out <= x_nxt;
          y_out <= y_nxt;
          z_out <= z_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Bench for cordic_iter_engine: directed test-plan cases plus randomized
// operations checked against a real-math reference model.
module tb_cordic_iter_engine;

  localparam int BW   = 16;
  localparam int ITER = 14;

  logic          clk, rst_n, start, mode_bit;
  logic [1:0]    coordinate_system;
  logic [BW-1:0] x_in, y_in, z_in;
  logic          busy, done, err;
  logic [BW-1:0] x_out, y_out, z_out;
  logic [5:0]    iter_idx;

  int n_cmp, n_fail;
  int hyp_seq[$];

  cordic_iter_engine #(.BIT_WIDTH(BW), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_bit(mode_bit),
    .coordinate_system(coordinate_system),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .busy(busy), .done(done), .err(err),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .iter_idx(iter_idx)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model
  function automatic int wrap16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic int angle(input logic [1:0] cs, input int i);
    real t;
    t = 2.0 ** (-i);
    if (cs == 2'b01) return $rtoi($atan(t) * 8192.0 + 0.5);
    if (cs == 2'b11) return $rtoi($atanh(t) * 8192.0 + 0.5);
    return $rtoi(t * 8192.0 + 0.5);
  endfunction

  function automatic void ref_op(input logic [1:0] cs, input logic mode,
                                 input logic [15:0] xi, yi, zi,
                                 output logic [15:0] xo, yo, zo, output logic eo);
    int x, y, z, m, d, i, xn;
    if (cs == 2'b10) begin
      xo = xi; yo = yi; zo = zi; eo = 1'b1;
      return;
    end
    x = int'($signed(xi)); y = int'($signed(yi)); z = int'($signed(zi));
    m = (cs == 2'b01) ? 1 : (cs == 2'b11) ? -1 : 0;
    for (int k = 0; k < ITER; k++) begin
      i  = (cs == 2'b11) ? hyp_seq[k] : k;
      d  = mode ? ((y < 0) ? 1 : -1) : ((z >= 0) ? 1 : -1);
      xn = wrap16(x - m * d * (y >>> i));
      y  = wrap16(y + d * (x >>> i));
      z  = wrap16(z - d * angle(cs, i));
      x  = xn;
    end
    xo = x[15:0]; yo = y[15:0]; zo = z[15:0]; eo = 1'b0;
  endfunction

  // Driver tasks
  task automatic launch(input logic [1:0] cs, input logic mode, input logic [15:0] xv, yv, zv);
    @(negedge clk);
    coordinate_system = cs; mode_bit = mode; x_in = xv; y_in = yv; z_in = zv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0; busy_cnt = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode_bit = 1'b0; coordinate_system = 2'b01;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if ({x_out, y_out, z_out} !== 48'd0) begin n_fail++; $display("FAIL reset_out: got %h want 0", {x_out, y_out, z_out}); end
    n_cmp++; if (iter_idx !== 6'd0) begin n_fail++; $display("FAIL reset_iter_idx: got %0d want 0", iter_idx); end
  endtask

  task automatic test_circular_rotation();
    logic [15:0] ex, ey, ez; logic ee; int cyc, bc, dv;
    ref_op(2'b01, 1'b0, 16'd8192, 16'd0, 16'd6434, ex, ey, ez, ee);
    launch(2'b01, 1'b0, 16'd8192, 16'd0, 16'd6434);
    wait_done(cyc, bc);
    n_cmp++; if (cyc !== ITER) begin n_fail++; $display("FAIL circ_rot_latency: got %0d want %0d", cyc, ITER); end
    n_cmp++; if (bc !== ITER) begin n_fail++; $display("FAIL circ_rot_busy_cycles: got %0d want %0d", bc, ITER); end
    n_cmp++; if (x_out !== ex) begin n_fail++; $display("FAIL circ_rot_x: got %0d want %0d", $signed(x_out), $signed(ex)); end
    n_cmp++; if (y_out !== ey) begin n_fail++; $display("FAIL circ_rot_y: got %0d want %0d", $signed(y_out), $signed(ey)); end
    n_cmp++; if (z_out !== ez) begin n_fail++; $display("FAIL circ_rot_z: got %0d want %0d", $signed(z_out), $signed(ez)); end
    dv = int'($signed(x_out)) - 9540;
    n_cmp++; if (dv < -8 || dv > 8) begin n_fail++; $display("FAIL circ_rot_x_tol: got %0d want 9540+-8", $signed(x_out)); end
    dv = int'($signed(y_out)) - 9540;
    n_cmp++; if (dv < -8 || dv > 8) begin n_fail++; $display("FAIL circ_rot_y_tol: got %0d want 9540+-8", $signed(y_out)); end
    dv = int'($signed(z_out));
    n_cmp++; if (dv < -4 || dv > 4) begin n_fail++; $display("FAIL circ_rot_z_tol: got %0d want 0+-4", $signed(z_out)); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_vectoring_linear();
    logic [15:0] ex, ey, ez; logic ee; int cyc, bc, dv;
    ref_op(2'b01, 1'b1, 16'd8192, 16'd8192, 16'd0, ex, ey, ez, ee);
    launch(2'b01, 1'b1, 16'd8192, 16'd8192, 16'd0);
    wait_done(cyc, bc);
    n_cmp++; if ({x_out, y_out, z_out} !== {ex, ey, ez}) begin n_fail++; $display("FAIL circ_vec_exact: got %h want %h", {x_out, y_out, z_out}, {ex, ey, ez}); end
    dv = int'($signed(z_out)) - 6434;
    n_cmp++; if (dv < -4 || dv > 4) begin n_fail++; $display("FAIL circ_vec_z_tol: got %0d want 6434+-4", $signed(z_out)); end
    dv = int'($signed(x_out)) - 19079;
    n_cmp++; if (dv < -8 || dv > 8) begin n_fail++; $display("FAIL circ_vec_x_tol: got %0d want 19079+-8", $signed(x_out)); end
    dv = int'($signed(y_out));
    n_cmp++; if (dv < -8 || dv > 8) begin n_fail++; $display("FAIL circ_vec_y_tol: got %0d want 0+-8", $signed(y_out)); end

    ref_op(2'b00, 1'b1, 16'd16384, 16'd8192, 16'd0, ex, ey, ez, ee);
    launch(2'b00, 1'b1, 16'd16384, 16'd8192, 16'd0);
    wait_done(cyc, bc);
    n_cmp++; if ({x_out, y_out, z_out} !== {ex, ey, ez}) begin n_fail++; $display("FAIL lin_vec_exact: got %h want %h", {x_out, y_out, z_out}, {ex, ey, ez}); end
    dv = int'($signed(z_out)) - 4096;
    n_cmp++; if (dv < -2 || dv > 2) begin n_fail++; $display("FAIL lin_vec_z_tol: got %0d want 4096+-2", $signed(z_out)); end

    ref_op(2'b00, 1'b0, 16'd8192, 16'd0, 16'd6144, ex, ey, ez, ee);
    launch(2'b00, 1'b0, 16'd8192, 16'd0, 16'd6144);
    wait_done(cyc, bc);
    n_cmp++; if ({x_out, y_out, z_out} !== {ex, ey, ez}) begin n_fail++; $display("FAIL lin_rot_exact: got %h want %h", {x_out, y_out, z_out}, {ex, ey, ez}); end
    dv = int'($signed(y_out)) - 6144;
    n_cmp++; if (dv < -2 || dv > 2) begin n_fail++; $display("FAIL lin_rot_y_tol: got %0d want 6144+-2", $signed(y_out)); end
  endtask

  task automatic test_hyperbolic();
    logic [15:0] ex, ey, ez; logic ee; int dv;
    ref_op(2'b11, 1'b0, 16'd8192, 16'd0, 16'd4096, ex, ey, ez, ee);
    launch(2'b11, 1'b0, 16'd8192, 16'd0, 16'd4096);
    for (int k = 0; k < ITER; k++) begin
      n_cmp++; if (iter_idx !== 6'(hyp_seq[k])) begin n_fail++; $display("FAIL hyp_idx_step%0d: got %0d want %0d", k, iter_idx, hyp_seq[k]); end
      @(negedge clk);
    end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL hyp_done: got %b want 1", done); end
    n_cmp++; if ({x_out, y_out, z_out} !== {ex, ey, ez}) begin n_fail++; $display("FAIL hyp_exact: got %h want %h", {x_out, y_out, z_out}, {ex, ey, ez}); end
    dv = int'($signed(x_out)) - 7650;
    n_cmp++; if (dv < -8 || dv > 8) begin n_fail++; $display("FAIL hyp_x_tol: got %0d want 7650+-8", $signed(x_out)); end
    dv = int'($signed(y_out)) - 3536;
    n_cmp++; if (dv < -8 || dv > 8) begin n_fail++; $display("FAIL hyp_y_tol: got %0d want 3536+-8", $signed(y_out)); end
  endtask

  task automatic test_reserved();
    int cyc, bc;
    launch(2'b10, 1'b0, 16'd5, 16'd6, 16'd7);
    wait_done(cyc, bc);
    n_cmp++; if (cyc !== 1) begin n_fail++; $display("FAIL rsv_latency: got %0d want 1", cyc); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rsv_err: got %b want 1", err); end
    n_cmp++; if ({x_out, y_out, z_out} !== {16'd5, 16'd6, 16'd7}) begin n_fail++; $display("FAIL rsv_out: got %0d/%0d/%0d want 5/6/7", x_out, y_out, z_out); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL rsv_err_hold: got err=%b done=%b want err=1 done=0", err, done); end
    launch(2'b01, 1'b0, 16'd100, 16'd0, 16'd0);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rsv_err_clear: got %b want 0", err); end
    wait_done(cyc, bc);
  endtask

  task automatic test_handshake();
    logic [15:0] ex, ey, ez, gx, gy, gz; logic ee; int n_done;
    ref_op(2'b01, 1'b0, 16'd4000, 16'd1000, 16'd2000, ex, ey, ez, ee);
    launch(2'b01, 1'b0, 16'd4000, 16'd1000, 16'd2000);
    repeat (3) @(negedge clk);
    x_in = 16'd123; y_in = 16'd456; z_in = 16'd789; coordinate_system = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; gx = '0; gy = '0; gz = '0;
    for (int c = 0; c < 2 * ITER; c++) begin
      if (done === 1'b1) begin n_done++; gx = x_out; gy = y_out; gz = z_out; end
      @(negedge clk);
    end
    n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL run_start_ignored_dones: got %0d want 1", n_done); end
    n_cmp++; if ({gx, gy, gz} !== {ex, ey, ez}) begin n_fail++; $display("FAIL run_start_ignored_result: got %h want %h", {gx, gy, gz}, {ex, ey, ez}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ax, ay, az, bx, by, bz; logic ee; int cyc, bc;
    ref_op(2'b01, 1'b1, 16'd6000, 16'hF000, 16'd0, ax, ay, az, ee);
    ref_op(2'b11, 1'b0, 16'd9000, 16'd500, 16'hFA00, bx, by, bz, ee);
    launch(2'b01, 1'b1, 16'd6000, 16'hF000, 16'd0);
    wait_done(cyc, bc);
    coordinate_system = 2'b11; mode_bit = 1'b0; x_in = 16'd9000; y_in = 16'd500; z_in = 16'hFA00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_relaunch: got done=%b busy=%b want done=0 busy=1", done, busy); end
    n_cmp++; if ({x_out, y_out, z_out} !== {ax, ay, az}) begin n_fail++; $display("FAIL b2b_hold_prior: got %h want %h", {x_out, y_out, z_out}, {ax, ay, az}); end
    wait_done(cyc, bc);
    n_cmp++; if (cyc !== ITER) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", cyc, ITER); end
    n_cmp++; if ({x_out, y_out, z_out} !== {bx, by, bz}) begin n_fail++; $display("FAIL b2b_second_result: got %h want %h", {x_out, y_out, z_out}, {bx, by, bz}); end
  endtask

  task automatic test_random();
    logic [15:0] xv, yv, zv, ex, ey, ez; logic [1:0] cs; logic md, ee; int cyc, bc;
    for (int n = 0; n < 40; n++) begin
      cs = 2'($urandom_range(0, 3)); md = 1'($urandom_range(0, 1));
      xv = 16'($urandom); yv = 16'($urandom); zv = 16'($urandom);
      ref_op(cs, md, xv, yv, zv, ex, ey, ez, ee);
      launch(cs, md, xv, yv, zv);
      wait_done(cyc, bc);
      n_cmp++; if (cyc !== ((cs == 2'b10) ? 1 : ITER)) begin n_fail++; $display("FAIL rand%0d_latency: got %0d cs=%b", n, cyc, cs); end
      n_cmp++; if ({x_out, y_out, z_out, err} !== {ex, ey, ez, ee}) begin n_fail++; $display("FAIL rand%0d_result cs=%b mode=%b in=%h/%h/%h: got %h/%h/%h err=%b want %h/%h/%h err=%b", n, cs, md, xv, yv, zv, x_out, y_out, z_out, err, ex, ey, ez, ee); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ex, ey, ez; logic ee; int cyc, bc;
    launch(2'b01, 1'b0, 16'd7000, 16'd2000, 16'd3000);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if ({x_out, y_out, z_out} !== 48'd0) begin n_fail++; $display("FAIL midreset_out: got %h want 0", {x_out, y_out, z_out}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done: got busy=%b done=%b want 0/0", busy, done); end
    ref_op(2'b01, 1'b1, 16'd3000, 16'd5000, 16'd0, ex, ey, ez, ee);
    launch(2'b01, 1'b1, 16'd3000, 16'd5000, 16'd0);
    wait_done(cyc, bc);
    n_cmp++; if ({x_out, y_out, z_out} !== {ex, ey, ez}) begin n_fail++; $display("FAIL midreset_next_op: got %h want %h", {x_out, y_out, z_out}, {ex, ey, ez}); end
  endtask

  // Sequence and report
  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 1; hyp_seq.size() < ITER; i++) begin
      hyp_seq.push_back(i);
      if ((i == 4 || i == 13 || i == 40) && hyp_seq.size() < ITER) hyp_seq.push_back(i);
    end
    test_reset();
    test_circular_rotation();
    test_vectoring_linear();
    test_hyperbolic();
    test_reserved();
    test_handshake();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_iter_engine.md
# cordic_iter_engine

Sequential, parametrised successor to the combinational CORDIC direction controller. It owns the full iterative datapath: the x/y/z registers, the shift-add update, the elaboration-time angle table and the per-iteration direction decision. It runs circular, linear or hyperbolic CORDIC in rotation or vectoring mode, completing one micro-rotation per clock. It sits between the operand-setup logic and the gain-compensation/output stage, and raw results are uncompensated.

## Interface
- BIT_WIDTH, 16: signed two's-complement width of x, y and z. FRAC = BIT_WIDTH-3 fractional bits, so the range is ±4.0.
- ITER, 14: micro-steps per operation. Legal range is 1..min(BIT_WIDTH-1, 63).
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: request, sampled in IDLE or DONE.
- mode_bit  in  1: 0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- coordinate_system  in  2: 2'b01 circular (m=+1), 2'b00 linear (m=0), 2'b11 hyperbolic (m=-1), 2'b10 reserved.
- x_in, y_in, z_in  in  BIT_WIDTH each: operands, latched on accept.
- busy  out  1: high while iterating.
- done  out  1: one-cycle pulse when results are valid.
- err  out  1: reserved coordinate system accepted; held until the next accept.
- x_out, y_out, z_out  out  BIT_WIDTH each: result registers, held until the next accept.
- iter_idx  out  6: shift index used by the current micro-step (debug).

## Operation
- States are IDLE, RUN and DONE.
  - IDLE to RUN on start.
  - RUN to DONE after ITER micro-steps.
  - DONE to IDLE unconditionally, or DONE to RUN if start is high (back-to-back).
- start is ignored in RUN.
- On accept:
  - latch x/y/z, mode and coordinate system;
  - step counter := 0; err := 0;
  - iter_idx := 1 for hyperbolic, otherwise 0.
- Direction d per micro-step, evaluated from the current registers:
  - rotation: d=+1 if z ≥ 0, else -1;
  - vectoring: d=+1 if y < 0, else -1.
- Update, with arithmetic (sign-extending) shift by i = iter_idx:
  - x' = x - m·d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z - d·e_i
- Angle table e_i is rounded to FRAC bits and computed at elaboration:
  - circular: atan(2^-i);
  - linear: 2^-i;
  - hyperbolic: atanh(2^-i).
- Index sequence:
  - circular and linear: i = step.
  - hyperbolic: starts at 1 and increments each step, except indices 4, 13 and 40 are each executed twice. Repeats count toward ITER, giving 1,2,3,4,4,5,…,13,13,14,…
- Arithmetic wraps modulo 2^BIT_WIDTH with no saturation. Operand range is the caller's responsibility.
- Reserved coordinate system (2'b10): there are no micro-steps. The next edge enters DONE with outputs equal to the latched inputs, err=1 and done=1.
- x_out/y_out/z_out are updated only on entry to DONE. During RUN they hold the previous result, or 0 after reset.

## Timing
- Reset (async assert, sync release): state IDLE; busy, done and err = 0; x_out, y_out, z_out = 0; iter_idx = 0; internal registers = 0.
- Accept edge E0 sets busy=1. Micro-step k executes at edge E(k+1).
- Edge E_ITER completes the last step and enters DONE: done=1, busy=0, outputs valid.
- Latency from accept edge to done is ITER cycles. Throughput is one operation per ITER+1 cycles, or per ITER cycles with back-to-back start in DONE.
- Back-to-back: start high in DONE gives done=0 and busy=1 on the next edge. Outputs keep the prior result until the new DONE.
- Reset asserted mid-RUN aborts immediately to reset values. No done is issued for the aborted operation.
- ITER=1: a single step with i=0 (or i=1 for hyperbolic), and done follows the accept by 1 cycle.

## Test plan
All values use BIT_WIDTH=16 and ITER=14, so 1.0 = 8192.

- **Circular rotation:** x=8192, y=0, z=6434 (π/4) → after 14 cycles done=1, x_out≈y_out≈9540 ±8, z_out within ±4 of 0. busy is high for exactly 14 cycles.
- **Circular vectoring and linear:**
  - Circular vectoring: x=8192, y=8192, z=0 → z_out≈6434 ±4, x_out≈19079 ±8, y_out within ±8 of 0.
  - Linear vectoring: x=16384, y=8192 → z_out≈4096 ±2.
  - Linear rotation: x=8192, z=6144 → y_out≈6144 ±2.
- **Hyperbolic rotation:** x=8192, y=0, z=4096 → x_out≈7650 ±8, y_out≈3536 ±8. The iter_idx trace reads 1,2,3,4,4,5,…,13.
- **Handshake:**
  - start pulsed in RUN is ignored, with exactly one done.
  - start held through DONE launches a second operation with no IDLE cycle.
  - done is a single-cycle pulse.
- **Reserved coordinate system:** coordinate_system=2'b10 with x=5, y=6, z=7 → done one cycle after accept, err=1, outputs 5/6/7.
- **Reset mid-operation:** rst_n low at step 5 → busy, done and outputs go to 0 asynchronously. A new operation after release matches its golden result.
